// File: rtl/div_arbiter_pkg.sv
// div_arbiter_pkg: FSM state encodings and defaults shared by the divider arbiter.
package div_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;
  localparam int TIMEOUT_CYCLES_DEF = 63;
endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin priority select; the first set request at or above ptr_i wins, with wrap-around.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o
);
  logic [W-1:0] k;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = W'((int'(ptr_i) + i) % N);
      if (req_i[k]) begin
        gnt_o = '0;
        gnt_o[k] = 1'b1;
        idx_o = k;
      end
    end
  end
endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: shares one iterative divider among NUM_REQ requesters, one divide in flight.
// Optional watchdog on the divider writeback is enabled with `define DIV_ARB_TIMEOUT_EN.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int REQ_IDX_W = 2
`ifdef DIV_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*32-1:0]   req_opcode_i,
  input  logic [NUM_REQ*32-1:0]   req_pc_i,
  input  logic [NUM_REQ*5-1:0]    req_rd_idx_i,
  input  logic [NUM_REQ*32-1:0]   req_ra_operand_i,
  input  logic [NUM_REQ*32-1:0]   req_rb_operand_i,
  input  logic [NUM_REQ-1:0]      kill_i,
  output logic                    div_valid_o,
  output logic [31:0]             div_opcode_o,
  output logic [31:0]             div_pc_o,
  output logic [4:0]              div_rd_idx_o,
  output logic [31:0]             div_ra_operand_o,
  output logic [31:0]             div_rb_operand_o,
  input  logic                    div_wb_valid_i,
  input  logic [31:0]             div_wb_value_i,
  output logic                    wb_valid_o,
  output logic [REQ_IDX_W-1:0]    wb_req_o,
  output logic [4:0]              wb_rd_idx_o,
  output logic [31:0]             wb_value_o,
  output logic                    busy_o,
  output logic                    err_timeout_o
);
  state_e                 state_q;
  logic [REQ_IDX_W-1:0]   rr_ptr_q, rr_ptr_d, owner_q, gnt_idx;
  logic [NUM_REQ-1:0]     gnt;
  logic                   discard_q, div_valid_q, wb_valid_q, err_q, hs, kill_own, to_hit;
  logic [31:0]            opc [NUM_REQ];
  logic [31:0]            pc [NUM_REQ];
  logic [4:0]             rd [NUM_REQ];
  logic [31:0]            ra [NUM_REQ];
  logic [31:0]            rb [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign opc[g] = req_opcode_i[g*32 +: 32];
    assign pc[g]  = req_pc_i[g*32 +: 32];
    assign rd[g]  = req_rd_idx_i[g*5 +: 5];
    assign ra[g]  = req_ra_operand_i[g*32 +: 32];
    assign rb[g]  = req_rb_operand_i[g*32 +: 32];
  end
  rr_arbiter #(.N(NUM_REQ), .W(REQ_IDX_W)) u_rr (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );
  // Gated by rst_i so every output reads 0 while reset is held.
  assign req_ready_o = (state_q == IDLE && !rst_i) ? gnt : '0;
  assign hs          = |req_ready_o;
  assign kill_own    = kill_i[owner_q];
  assign rr_ptr_d    = (gnt_idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign busy_o      = state_q != IDLE;
  assign div_valid_o = div_valid_q;
  assign wb_valid_o  = wb_valid_q;
`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
  end
  assign to_hit = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif
  assign err_timeout_o = err_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      rr_ptr_q         <= '0;
      owner_q          <= '0;
      discard_q        <= 1'b0;
      div_valid_q      <= 1'b0;
      div_opcode_o     <= '0;
      div_pc_o         <= '0;
      div_rd_idx_o     <= '0;
      div_ra_operand_o <= '0;
      div_rb_operand_o <= '0;
      wb_valid_q       <= 1'b0;
      wb_req_o         <= '0;
      wb_rd_idx_o      <= '0;
      wb_value_o       <= '0;
      err_q            <= 1'b0;
    end else begin
      div_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: if (hs) begin
          div_opcode_o     <= opc[gnt_idx];
          div_pc_o         <= pc[gnt_idx];
          div_rd_idx_o     <= rd[gnt_idx];
          div_ra_operand_o <= ra[gnt_idx];
          div_rb_operand_o <= rb[gnt_idx];
          owner_q          <= gnt_idx;
          rr_ptr_q         <= rr_ptr_d;
          discard_q        <= kill_i[gnt_idx];
          div_valid_q      <= 1'b1;
          state_q          <= ISSUE;
        end
        ISSUE: begin
          discard_q <= discard_q | kill_own;
          state_q   <= WAIT;
        end
        WAIT: if (div_wb_valid_i) begin
          wb_valid_q  <= !(discard_q | kill_own);
          wb_req_o    <= owner_q;
          wb_rd_idx_o <= div_rd_idx_o;
          wb_value_o  <= div_wb_value_i;
          state_q     <= IDLE;
        end else begin
          discard_q <= discard_q | kill_own;
          if (to_hit) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed bench; the bench plays the divider and answers with hand-computed results.
module tb_div_arbiter;
  logic         clk = 0, rst = 1;
  logic [3:0]   req_valid = '0, req_ready, kill = '0;
  logic [127:0] req_opcode = '0, req_pc = '0, req_ra = '0, req_rb = '0;
  logic [19:0]  req_rd = '0;
  logic         div_valid, div_wb_valid = 0, wb_valid, busy, err;
  logic [31:0]  div_opcode, div_pc, div_ra, div_rb, div_wb_value = '0, wb_value;
  logic [4:0]   div_rd, wb_rd;
  logic [1:0]   wb_req;
  int           checks = 0, errors = 0;
  logic         stray;

  div_arbiter dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_opcode_i(req_opcode), .req_pc_i(req_pc), .req_rd_idx_i(req_rd),
    .req_ra_operand_i(req_ra), .req_rb_operand_i(req_rb), .kill_i(kill),
    .div_valid_o(div_valid), .div_opcode_o(div_opcode), .div_pc_o(div_pc),
    .div_rd_idx_o(div_rd), .div_ra_operand_o(div_ra), .div_rb_operand_o(div_rb),
    .div_wb_valid_i(div_wb_valid), .div_wb_value_i(div_wb_value),
    .wb_valid_o(wb_valid), .wb_req_o(wb_req), .wb_rd_idx_o(wb_rd), .wb_value_o(wb_value),
    .busy_o(busy), .err_timeout_o(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_slot(input int k, input logic [31:0] ra, input logic [31:0] rb, input logic [4:0] rd);
    req_opcode[k*32 +: 32] = 32'h0200_4033 ^ 32'(k);
    req_pc[k*32 +: 32]     = 32'h1000 + 32'(k * 4);
    req_ra[k*32 +: 32]     = ra;
    req_rb[k*32 +: 32]     = rb;
    req_rd[k*5 +: 5]       = rd;
  endtask

  // Handshake at cycle T, divider answers at T+lat; optional kill pulse on kill_k at T+kill_cyc.
  task automatic run_op(input int k, input logic [31:0] ra, input logic [31:0] rb, input logic [4:0] rd,
                        input int lat, input logic [31:0] res, input int kill_k, input int kill_cyc,
                        input logic exp_wb);
    load_slot(k, ra, rb, rd);
    req_valid[k] = 1'b1;
    #1;
    chk("grant", 64'(req_ready), 64'd1 << k);
    tick;
    req_valid[k] = 1'b0;
    chk("div_valid", 64'(div_valid), 1);
    chk("div_ra", 64'(div_ra), 64'(ra));
    chk("div_rb", 64'(div_rb), 64'(rb));
    chk("div_rd", 64'(div_rd), 64'(rd));
    chk("div_opcode", 64'(div_opcode), 64'(32'h0200_4033 ^ 32'(k)));
    chk("div_pc", 64'(div_pc), 64'(32'h1000 + 32'(k * 4)));
    chk("busy", 64'(busy), 1);
    stray = 1'b0;
    for (int c = 2; c <= lat; c++) begin
      tick;
      kill = '0;
      stray = stray | div_valid | wb_valid | (|req_ready) | ~busy | err;
      if (c == kill_cyc) kill[kill_k] = 1'b1;
      if (c == lat) begin
        div_wb_valid = 1'b1;
        div_wb_value = res;
      end
    end
    tick;
    kill = '0;
    div_wb_valid = 1'b0;
    chk("stray", 64'(stray), 0);
    chk("wb_valid", 64'(wb_valid), 64'(exp_wb));
    chk("busy_done", 64'(busy), 0);
    if (exp_wb) begin
      chk("wb_value", 64'(wb_value), 64'(res));
      chk("wb_req", 64'(wb_req), 64'(k));
      chk("wb_rd", 64'(wb_rd), 64'(rd));
    end
  endtask

  initial begin
    tick;
    tick;
    chk("rst_ready", 64'(req_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_div_valid", 64'(div_valid), 0);
    chk("rst_wb_valid", 64'(wb_valid), 0);
    chk("rst_err", 64'(err), 0);
    rst = 1'b0;
    // All four requesters held valid from reset: grants 0,1,2,3,0, never overlapping.
    for (int k = 0; k < 4; k++) load_slot(k, 32'd40 + 32'(k), 32'd4, 5'(8 + k));
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_grant", 64'(req_ready), 64'd1 << (i % 4));
      tick;
      chk("rr_busy", 64'(busy), 1);
      stray = 1'b0;
      for (int c = 2; c <= 35; c++) begin
        tick;
        stray = stray | (|req_ready) | ~busy | div_valid;
        if (c == 35) begin
          div_wb_valid = 1'b1;
          div_wb_value = 32'd10;
        end
      end
      tick;
      div_wb_valid = 1'b0;
      chk("rr_stray", 64'(stray), 0);
      chk("rr_wb_valid", 64'(wb_valid), 1);
      chk("rr_wb_req", 64'(wb_req), 64'(i % 4));
      chk("rr_wb_rd", 64'(wb_rd), 64'(8 + (i % 4)));
    end
    req_valid = '0;
    tick;
    // Single DIV 100/7 from requester 2.
    run_op(2, 32'd100, 32'd7, 5'd17, 35, 32'd14, 0, 0, 1'b1);
    // DIVU 0xFFFFFFFF/3 twice; second one hits the divider short-cut and is granted in the wb cycle.
    run_op(3, 32'hFFFF_FFFF, 32'd3, 5'd5, 35, 32'h5555_5555, 0, 0, 1'b1);
    run_op(3, 32'hFFFF_FFFF, 32'd3, 5'd5, 3, 32'h5555_5555, 0, 0, 1'b1);
    tick;
    chk("wb_pulse", 64'(wb_valid), 0);
    chk("wb_hold", 64'(wb_value), 64'h5555_5555);
    // REM from requester 1 killed mid-WAIT, then next grant right after the discarded writeback.
    run_op(1, 32'd100, 32'd7, 5'd9, 35, 32'd2, 1, 20, 1'b0);
    run_op(0, 32'd45, 32'd9, 5'd3, 35, 32'd5, 2, 10, 1'b1);
    // Kill arriving in the same cycle as the divider writeback.
    run_op(2, 32'd50, 32'd5, 5'd4, 35, 32'd10, 2, 35, 1'b0);
    // Reset during WAIT.
    load_slot(2, 32'd9, 32'd3, 5'd6);
    req_valid[2] = 1'b1;
    tick;
    req_valid[2] = 1'b0;
    tick;
    tick;
    chk("pre_rst_busy", 64'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_div_ra", 64'(div_ra), 0);
    chk("mid_rst_div_rd", 64'(div_rd), 0);
    chk("mid_rst_wb_value", 64'(wb_value), 0);
    chk("mid_rst_wb_req", 64'(wb_req), 0);
    tick;
    rst = 1'b0;
    // Pointer back at 0: with 0 and 3 both requesting, 0 wins.
    load_slot(3, 32'd1, 32'd1, 5'd1);
    req_valid[3] = 1'b1;
    run_op(0, 32'd1000, 32'd10, 5'd30, 35, 32'd100, 0, 0, 1'b1);
    req_valid = '0;
    tick;
`ifdef DIV_ARB_TIMEOUT_EN
    load_slot(1, 32'd7, 32'd7, 5'd2);
    req_valid[1] = 1'b1;
    tick;
    req_valid[1] = 1'b0;
    stray = 1'b0;
    for (int c = 2; c <= 64; c++) begin
      tick;
      stray = stray | err | wb_valid | ~busy;
    end
    chk("to_early", 64'(stray), 0);
    tick;
    chk("to_err", 64'(err), 1);
    chk("to_idle", 64'(busy), 0);
    chk("to_no_wb", 64'(wb_valid), 0);
    tick;
    chk("to_pulse", 64'(err), 0);
`else
    chk("err_off", 64'(err), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
